pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for I_mem_ready in FETCH or MEM before error (range 1..255).
REQ-002 I_clk  input  1  single clock; all state changes on rising edge.
REQ-003 I_rst_n  input  1  asynchronous, active-low reset.
REQ-004 I_run  input  1  level; 1 = execute instructions, 0 = return to IDLE after current instruction retires.
REQ-005 I_resume  input  1  single-cycle pulse; leaves HALT.
REQ-006 I_halt  input  1  decoded halt opcode, valid in REGRD.
REQ-007 I_mem_op  input  1  decoded load/store flag, valid in ALU.
REQ-008 I_mem_ready  input  1  memory handshake acknowledge for O_mem_req.
REQ-009 O_en_fetch, O_en_dec, O_en_rreg, O_en_alu, O_en_mem, O_en_wb  output  1 each  stage enables; decoder I_en is driven from O_en_dec.
REQ-010 O_mem_req  output  1  memory request, asserted in FETCH and MEM.
REQ-011 O_state  output  3  current state encoding.
REQ-012 O_busy  output  1  1 in any state other than IDLE and HALT.
REQ-013 O_err  output  1  sticky memory-timeout flag.
REQ-014 O_retired  output  16  count of retired instructions.

Function
REQ-015 States and encoding: IDLE=0, FETCH=1, DECODE=2, REGRD=3, ALU=4, MEM=5, WB=6, HALT=7.
REQ-016 All outputs are registered Moore outputs of the state; exactly one O_en_* is 1 in states 1..6, none in IDLE/HALT.
REQ-017 IDLE -> FETCH when I_run=1, else stay.
REQ-018 FETCH -> DECODE on the cycle I_mem_ready=1 is sampled; else stay and increment wait counter.
REQ-019 DECODE -> REGRD unconditionally (one cycle; decoder samples on the following falling edge).
REQ-020 REGRD -> HALT if I_halt=1, else ALU; a halted instruction is not retired.
REQ-021 ALU -> MEM if I_mem_op=1, else WB.
REQ-022 MEM -> WB on sampled I_mem_ready=1; else stay and increment wait counter.
REQ-023 WB -> FETCH if I_run=1, else IDLE; O_retired increments by 1 on WB exit, wrapping 0xFFFF -> 0x0000.
REQ-024 Wait counter (8 bits) clears on entry to FETCH or MEM; if it reaches MEM_TIMEOUT with I_mem_ready still 0, next state is HALT and O_err sets to 1.
REQ-025 I_mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: handshake wins, normal transition, O_err unchanged.
REQ-026 I_mem_ready outside FETCH/MEM is ignored.
REQ-027 HALT -> IDLE on I_resume=1; O_err clears on that transition; otherwise stay.
REQ-028 I_run deassertion mid-instruction does not abort; instruction completes through WB, then IDLE.
REQ-029 I_resume outside HALT is ignored.
REQ-030 Minimum instruction latency: non-memory 5 cycles FETCH..WB with zero-wait memory; memory instruction 6 cycles.

Reset
REQ-031 I_rst_n=0 forces immediately, regardless of clock: state IDLE, all O_en_* 0, O_mem_req 0, O_busy 0, O_err 0, O_retired 0, wait counter 0, O_state 0.
REQ-032 Reset asserted mid-operation (any state, including pending memory handshake) abandons the instruction without retiring it.
REQ-033 After release, first state change occurs on the first rising edge with I_rst_n=1.

Verification
REQ-034 Reset, I_run=1, I_mem_ready=1 constant, I_mem_op=0, I_halt=0 -> O_state sequence 0,1,2,3,4,6,1,...; O_retired=1 after first WB, 2 after second.
REQ-035 I_mem_op=1, I_mem_ready low 3 cycles in MEM then high -> MEM held 4 cycles, O_mem_req=1 throughout, then WB, O_retired+1.
REQ-036 MEM_TIMEOUT=15, I_mem_ready=0 in FETCH -> HALT after 15 wait cycles, O_err=1, O_busy=0; I_resume pulse -> IDLE, O_err=0.
REQ-037 I_halt=1 in REGRD -> HALT, O_retired unchanged; I_resume with I_run=1 -> IDLE then FETCH next cycle.
REQ-038 Preload O_retired to 0xFFFF via 65535 instructions (or forced) -> next WB gives 0x0000.
REQ-039 I_run dropped during ALU -> WB completes, O_retired+1, then IDLE; I_rst_n pulsed low in MEM -> immediate IDLE, all outputs at reset values.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake and status bundle between the pipeline controller and its surroundings.
// The slave side is the controller; the master side is whoever drives instructions.
interface pipe_ctrl_if;
  logic        I_run;
  logic        I_resume;
  logic        I_halt;
  logic        I_mem_op;
  logic        I_mem_ready;
  logic        O_en_fetch;
  logic        O_en_dec;
  logic        O_en_rreg;
  logic        O_en_alu;
  logic        O_en_mem;
  logic        O_en_wb;
  logic        O_mem_req;
  logic [2:0]  O_state;
  logic        O_busy;
  logic        O_err;
  logic [15:0] O_retired;

  modport slave (
    input  I_run, I_resume, I_halt, I_mem_op, I_mem_ready,
    output O_en_fetch, O_en_dec, O_en_rreg, O_en_alu, O_en_mem, O_en_wb,
    output O_mem_req, O_state, O_busy, O_err, O_retired
  );

  modport master (
    output I_run, I_resume, I_halt, I_mem_op, I_mem_ready,
    input  O_en_fetch, O_en_dec, O_en_rreg, O_en_alu, O_en_mem, O_en_wb,
    input  O_mem_req, O_state, O_busy, O_err, O_retired
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Multi-cycle instruction sequencer: walks FETCH..WB, waits on memory with a timeout,
// and parks in HALT on a halt opcode or a memory timeout. All outputs are registered.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StRegrd  = 3'd3,
    StAlu    = 3'd4,
    StMem    = 3'd5,
    StWb     = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] retired_q, retired_d;
  logic [5:0]  en_q, en_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    err_d     = err_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle:   if (bus.I_run) state_d = StFetch;
      StFetch, StMem: begin
        // A handshake on the timeout cycle still wins over the timeout.
        if (bus.I_mem_ready) begin
          state_d = (state_q == StFetch) ? StDecode : StWb;
        end else if (wait_q == TimeoutCnt) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: state_d = StRegrd;
      StRegrd:  state_d = bus.I_halt ? StHalt : StAlu;
      StAlu:    state_d = bus.I_mem_op ? StMem : StWb;
      StWb: begin
        state_d   = bus.I_run ? StFetch : StIdle;
        retired_d = retired_q + 16'd1;
      end
      StHalt: begin
        if (bus.I_resume) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    en_d = '0;
    unique case (state_d)
      StFetch:  en_d[0] = 1'b1;
      StDecode: en_d[1] = 1'b1;
      StRegrd:  en_d[2] = 1'b1;
      StAlu:    en_d[3] = 1'b1;
      StMem:    en_d[4] = 1'b1;
      StWb:     en_d[5] = 1'b1;
      default:  en_d    = '0;
    endcase
    mem_req_d = (state_d == StFetch) || (state_d == StMem);
    busy_d    = (state_d != StIdle) && (state_d != StHalt);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
      en_q      <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      en_q      <= en_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.O_state    = state_q;
  assign bus.O_en_fetch = en_q[0];
  assign bus.O_en_dec   = en_q[1];
  assign bus.O_en_rreg  = en_q[2];
  assign bus.O_en_alu   = en_q[3];
  assign bus.O_en_mem   = en_q[4];
  assign bus.O_en_wb    = en_q[5];
  assign bus.O_mem_req  = mem_req_q;
  assign bus.O_busy     = busy_q;
  assign bus.O_err      = err_q;
  assign bus.O_retired  = retired_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl; expected traces are built per instruction
// from the stage rules and compared cycle by cycle on the falling clock edge.
module tb_pipe_ctrl;
  localparam int unsigned TO = 15;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [15:0] exp_ret;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] obs_en();
    return {bus.O_en_wb, bus.O_en_mem, bus.O_en_alu, bus.O_en_rreg, bus.O_en_dec,
            bus.O_en_fetch};
  endfunction

  // One-hot stage enable required for each state code; none in IDLE/HALT.
  function automatic logic [5:0] exp_en(input logic [2:0] s);
    logic [5:0] one;
    one = 6'd1;
    if (s >= 3'd1 && s <= 3'd6) return one << (s - 3'd1);
    return 6'd0;
  endfunction

  function automatic logic exp_busy(input logic [2:0] s);
    return (s != 3'd0) && (s != 3'd7);
  endfunction

  function automatic logic exp_req(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd5);
  endfunction

  task automatic drive(input logic run, rdy, halt, mop, resume);
    bus.I_run       = run;
    bus.I_mem_ready = rdy;
    bus.I_halt      = halt;
    bus.I_mem_op    = mop;
    bus.I_resume    = resume;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    checks++;
    if (bus.O_state !== 3'd0 || obs_en() !== 6'd0 || bus.O_mem_req !== 1'b0 ||
        bus.O_busy !== 1'b0 || bus.O_err !== 1'b0 || bus.O_retired !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: state=%0d en=%b req=%b busy=%b err=%b ret=%h, want all 0",
               bus.O_state, obs_en(), bus.O_mem_req, bus.O_busy, bus.O_err, bus.O_retired);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: state=%0d want 0", bus.O_state);
    end
    exp_ret = 16'd0;
  endtask

  // Random instruction stream: expected states are assembled instruction by instruction.
  task automatic test_stream(input int n);
    logic [2:0] es[$];
    logic       runq[$], rdyq[$], hq[$], mq[$];
    logic [15:0] ret;
    int fw, mw;
    logic mop;
    es.push_back(3'd0); runq.push_back(1'b1); rdyq.push_back(1'($urandom_range(0, 1)));
    hq.push_back(1'($urandom_range(0, 1))); mq.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < n; i++) begin
      fw  = ($urandom_range(0, 7) == 0) ? int'(TO) : int'($urandom_range(0, 3));
      mw  = ($urandom_range(0, 7) == 0) ? int'(TO) : int'($urandom_range(0, 3));
      mop = 1'($urandom_range(0, 1));
      for (int j = 0; j <= fw; j++) begin
        es.push_back(3'd1); rdyq.push_back(j == fw); runq.push_back(1'($urandom_range(0, 1)));
        hq.push_back(1'($urandom_range(0, 1))); mq.push_back(1'($urandom_range(0, 1)));
      end
      es.push_back(3'd2); rdyq.push_back(1'($urandom_range(0, 1)));
      runq.push_back(1'($urandom_range(0, 1)));
      hq.push_back(1'($urandom_range(0, 1))); mq.push_back(1'($urandom_range(0, 1)));
      es.push_back(3'd3); rdyq.push_back(1'($urandom_range(0, 1)));
      runq.push_back(1'($urandom_range(0, 1))); hq.push_back(1'b0);
      mq.push_back(1'($urandom_range(0, 1)));
      es.push_back(3'd4); rdyq.push_back(1'($urandom_range(0, 1)));
      runq.push_back(1'($urandom_range(0, 1))); hq.push_back(1'($urandom_range(0, 1)));
      mq.push_back(mop);
      if (mop) begin
        for (int j = 0; j <= mw; j++) begin
          es.push_back(3'd5); rdyq.push_back(j == mw); runq.push_back(1'($urandom_range(0, 1)));
          hq.push_back(1'($urandom_range(0, 1))); mq.push_back(1'($urandom_range(0, 1)));
        end
      end
      es.push_back(3'd6); rdyq.push_back(1'($urandom_range(0, 1)));
      runq.push_back(i != n - 1); hq.push_back(1'($urandom_range(0, 1)));
      mq.push_back(1'($urandom_range(0, 1)));
    end
    es.push_back(3'd0); runq.push_back(1'b0); rdyq.push_back(1'b0);
    hq.push_back(1'b0); mq.push_back(1'b0);

    ret = exp_ret;
    for (int k = 0; k < es.size(); k++) begin
      checks++;
      if (bus.O_state !== es[k]) begin
        errors++;
        $display("FAIL stream_state[%0d]: state=%0d want %0d", k, bus.O_state, es[k]);
      end
      checks++;
      if (obs_en() !== exp_en(es[k]) || bus.O_mem_req !== exp_req(es[k]) ||
          bus.O_busy !== exp_busy(es[k]) || bus.O_err !== 1'b0) begin
        errors++;
        $display("FAIL stream_outs[%0d]: en=%b req=%b busy=%b err=%b want en=%b req=%b busy=%b err=0",
                 k, obs_en(), bus.O_mem_req, bus.O_busy, bus.O_err, exp_en(es[k]),
                 exp_req(es[k]), exp_busy(es[k]));
      end
      checks++;
      if (bus.O_retired !== ret) begin
        errors++;
        $display("FAIL stream_retired[%0d]: retired=%0d want %0d", k, bus.O_retired, ret);
      end
      if (es[k] == 3'd6) ret = ret + 16'd1;
      drive(runq[k], rdyq[k], hq[k], mq[k], 1'($urandom_range(0, 1)) & (es[k] == 3'd0) & 1'b0);
      @(negedge clk);
    end
    exp_ret = ret;
  endtask

  // Memory never answers in FETCH (in_mem=0) or in MEM (in_mem=1).
  task automatic test_timeout(input logic in_mem);
    logic [2:0] ws;
    ws = in_mem ? 3'd5 : 3'd1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if (in_mem) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i <= int'(TO); i++) begin
      checks++;
      if (bus.O_state !== ws || bus.O_mem_req !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: state=%0d req=%b want %0d req=1",
                 i, bus.O_state, bus.O_mem_req, ws);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    checks++;
    if (bus.O_state !== 3'd7 || bus.O_err !== 1'b1 || bus.O_busy !== 1'b0 ||
        obs_en() !== 6'd0 || bus.O_mem_req !== 1'b0 || bus.O_retired !== exp_ret) begin
      errors++;
      $display("FAIL timeout_halt: state=%0d err=%b busy=%b en=%b req=%b ret=%0d want 7 1 0 0 0 %0d",
               bus.O_state, bus.O_err, bus.O_busy, obs_en(), bus.O_mem_req, bus.O_retired,
               exp_ret);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd0 || bus.O_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resume: state=%0d err=%b want 0 0", bus.O_state, bus.O_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd0) begin
      errors++;
      $display("FAIL resume_in_idle: state=%0d want 0", bus.O_state);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Let the current instruction finish with run low; bounded wait for IDLE.
  task automatic finish_to_idle(input string name);
    int n;
    n = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (bus.O_state !== 3'd0 && n < 20) begin
      if (bus.O_state === 3'd6) exp_ret = exp_ret + 16'd1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.O_state !== 3'd0 || bus.O_retired !== exp_ret) begin
      errors++;
      $display("FAIL %s: state=%0d retired=%0d want 0 %0d", name, bus.O_state, bus.O_retired,
               exp_ret);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd3) begin
      errors++;
      $display("FAIL halt_regrd: state=%0d want 3", bus.O_state);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd7 || bus.O_retired !== exp_ret || bus.O_err !== 1'b0 ||
        bus.O_busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: state=%0d ret=%0d err=%b busy=%b want 7 %0d 0 0",
               bus.O_state, bus.O_retired, bus.O_err, bus.O_busy, exp_ret);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd0) begin
      errors++;
      $display("FAIL halt_resume: state=%0d want 0", bus.O_state);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd1) begin
      errors++;
      $display("FAIL halt_refetch: state=%0d want 1", bus.O_state);
    end
    finish_to_idle("halt_finish");
  endtask

  task automatic test_run_drop();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd4) begin
      errors++;
      $display("FAIL drop_alu: state=%0d want 4", bus.O_state);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd6) begin
      errors++;
      $display("FAIL drop_wb: state=%0d want 6", bus.O_state);
    end
    exp_ret = exp_ret + 16'd1;
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd0 || bus.O_retired !== exp_ret) begin
      errors++;
      $display("FAIL drop_idle: state=%0d ret=%0d want 0 %0d", bus.O_state, bus.O_retired,
               exp_ret);
    end
  endtask

  task automatic test_wrap();
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    checks++;
    if (bus.O_retired !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: retired=%h want ffff", bus.O_retired);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    finish_to_idle("wrap_zero");
    checks++;
    if (bus.O_retired !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_value: retired=%h want 0000", bus.O_retired);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd5) begin
      errors++;
      $display("FAIL rstmid_mem: state=%0d want 5", bus.O_state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.O_state !== 3'd0 || obs_en() !== 6'd0 || bus.O_mem_req !== 1'b0 ||
        bus.O_busy !== 1'b0 || bus.O_err !== 1'b0 || bus.O_retired !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_async: state=%0d en=%b req=%b busy=%b err=%b ret=%h want all 0",
               bus.O_state, obs_en(), bus.O_mem_req, bus.O_busy, bus.O_err, bus.O_retired);
    end
    exp_ret = 16'd0;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.O_state !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_release: state=%0d want 1", bus.O_state);
    end
    finish_to_idle("rstmid_finish");
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_ret = 16'd0;
    test_reset();
    test_stream(30);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_halt();
    test_run_drop();
    test_wrap();
    test_stream(15);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
